// File: rtl/flip_flop_d.sv
// Positive-edge D flip-flop with synchronous clear (active-high, highest
// priority), synchronous active-low preset, and true/complement outputs.
module flip_flop_d #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic             clockpulse,
    input  logic             clear,
    input  logic             preset,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] signal_q,
    output logic [WIDTH-1:0] signal_q_
);

    // No reset-less initial value: Q is undefined until the first rising edge.
    always_ff @(posedge clockpulse) begin
        if (clear) begin
            signal_q <= CLEAR_VALUE;
        end else if (!preset) begin
            signal_q <= '1;
        end else begin
            signal_q <= data;
        end
    end

    // Derived only from the register, so no input reaches Q_ combinationally.
    assign signal_q_ = ~signal_q;

endmodule

// File: tb/tb_flip_flop_d.sv
// Bench for flip_flop_d: two 4-bit instances (default and non-zero clear value)
// driven in lockstep, checked against an expected-value queue after each edge.
module tb_flip_flop_d;

    localparam int           W  = 4;
    localparam logic [W-1:0] CV = 4'b0110;

    logic         clockpulse;
    logic         clear;
    logic         preset;
    logic [W-1:0] data;
    logic [W-1:0] q, qn;
    logic [W-1:0] q2, qn2;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_cv_q[$];
    int           vectors     = 0;
    int           miscompares = 0;

    flip_flop_d #(.WIDTH(W)) dut (
        .clockpulse (clockpulse),
        .clear      (clear),
        .preset     (preset),
        .data       (data),
        .signal_q   (q),
        .signal_q_  (qn)
    );

    flip_flop_d #(.WIDTH(W), .CLEAR_VALUE(CV)) dut_cv (
        .clockpulse (clockpulse),
        .clear      (clear),
        .preset     (preset),
        .data       (data),
        .signal_q   (q2),
        .signal_q_  (qn2)
    );

    // Rising edges at 100 ns, 200 ns, ...; high for 50 ns.
    initial begin
        clockpulse = 1'b0;
        #100;
        forever begin
            clockpulse = 1'b1;
            #50;
            clockpulse = 1'b0;
            #50;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic apply(input logic clr, input logic pre, input logic [W-1:0] d);
        clear  = clr;
        preset = pre;
        data   = d;
        exp_q.push_back(clr ? '0 : (!pre ? '1 : d));
        exp_cv_q.push_back(clr ? CV : (!pre ? '1 : d));
    endtask

    task automatic to_low;
        @(negedge clockpulse);
        #10;
    endtask

    task automatic next_edge;
        @(posedge clockpulse);
        #5;
    endtask

    task automatic test_reset;
        logic [W-1:0] e, e2;
        #20;
        apply(1'b1, 1'b1, '1);
        next_edge();
        e = exp_q.pop_front();
        e2 = exp_cv_q.pop_front();
        vectors++;
        if (q !== e || qn !== ~e || q2 !== e2 || qn2 !== ~e2) begin
            miscompares++;
            $display("FAIL reset: q=%b qn=%b q2=%b qn2=%b, expected q=%b qn=%b q2=%b qn2=%b",
                     q, qn, q2, qn2, e, ~e, e2, ~e2);
        end
    endtask

    task automatic test_capture;
        logic [W-1:0] vals[6];
        logic [W-1:0] e, e2;
        vals = '{4'b0000, 4'b1111, 4'b0000, 4'b1001, 4'b0110, 4'b0000};
        for (int i = 0; i < 6; i++) begin
            to_low();
            apply(1'b0, 1'b1, vals[i]);
            next_edge();
            e = exp_q.pop_front();
            e2 = exp_cv_q.pop_front();
            vectors++;
            if (q !== e || qn !== ~e || q2 !== e2 || qn2 !== ~e2) begin
                miscompares++;
                $display("FAIL capture[%0d]: q=%b qn=%b q2=%b, expected q=%b qn=%b q2=%b",
                         i, q, qn, q2, e, ~e, e2);
            end
        end
    endtask

    task automatic test_edge_sensitivity;
        // Q was loaded with 0; data glitches in both clock phases must not leak.
        logic [W-1:0] t_data[4];
        int           t_wait[4];
        t_data = '{4'b1111, 4'b0000, 4'b1111, 4'b0000};
        t_wait = '{15, 20, 30, 20};
        for (int i = 0; i < 4; i++) begin
            #(t_wait[i]);
            data = t_data[i];
            #3;
            vectors++;
            if (q !== 4'b0000 || qn !== 4'b1111) begin
                miscompares++;
                $display("FAIL edge_sens[%0d]: q=%b qn=%b, expected q=0000 qn=1111", i, q, qn);
            end
        end
        next_edge();
        vectors++;
        if (q !== 4'b0000 || qn !== 4'b1111) begin
            miscompares++;
            $display("FAIL edge_sens_capture: q=%b qn=%b, expected q=0000 qn=1111", q, qn);
        end
    endtask

    task automatic test_hold_high;
        logic [W-1:0] e, e2;
        to_low();
        apply(1'b0, 1'b1, '1);
        next_edge();
        e = exp_q.pop_front();
        e2 = exp_cv_q.pop_front();
        vectors++;
        if (q !== e || qn !== ~e || q2 !== e2) begin
            miscompares++;
            $display("FAIL hold_load: q=%b qn=%b, expected q=%b qn=%b", q, qn, e, ~e);
        end
        for (int i = 0; i < 4; i++) begin
            #15;
            data = (i % 2 == 0) ? 4'b0000 : 4'b1111;
            #5;
            vectors++;
            if (q !== 4'b1111 || qn !== 4'b0000) begin
                miscompares++;
                $display("FAIL hold_toggle[%0d]: q=%b qn=%b, expected q=1111 qn=0000", i, q, qn);
            end
        end
    endtask

    task automatic test_sync_clear;
        logic [W-1:0] e, e2;
        to_low();
        apply(1'b1, 1'b1, '1);
        #20;
        vectors++;
        if (q !== 4'b1111 || q2 !== 4'b1111 || qn !== 4'b0000) begin
            miscompares++;
            $display("FAIL clear_early: q=%b q2=%b qn=%b, expected q=1111 q2=1111 qn=0000", q, q2, qn);
        end
        next_edge();
        e = exp_q.pop_front();
        e2 = exp_cv_q.pop_front();
        vectors++;
        if (q !== e || qn !== ~e || q2 !== e2 || qn2 !== ~e2) begin
            miscompares++;
            $display("FAIL clear_edge: q=%b qn=%b q2=%b qn2=%b, expected q=%b qn=%b q2=%b qn2=%b",
                     q, qn, q2, qn2, e, ~e, e2, ~e2);
        end
        to_low();
        apply(1'b0, 1'b1, '1);
        next_edge();
        e = exp_q.pop_front();
        e2 = exp_cv_q.pop_front();
        vectors++;
        if (q !== e || qn !== ~e || q2 !== e2) begin
            miscompares++;
            $display("FAIL clear_release: q=%b qn=%b q2=%b, expected q=%b qn=%b q2=%b", q, qn, q2, e, ~e, e2);
        end
    endtask

    task automatic test_preset_priority;
        logic         clr_v[4];
        logic         pre_v[4];
        logic [W-1:0] d_v[4];
        logic [W-1:0] e, e2;
        clr_v = '{1'b0, 1'b1, 1'b0, 1'b0};
        pre_v = '{1'b0, 1'b0, 1'b1, 1'b1};
        d_v   = '{4'b0000, 4'b0000, 4'b0101, 4'b1010};
        for (int i = 0; i < 4; i++) begin
            to_low();
            apply(clr_v[i], pre_v[i], d_v[i]);
            next_edge();
            e = exp_q.pop_front();
            e2 = exp_cv_q.pop_front();
            vectors++;
            if (q !== e || qn !== ~e || q2 !== e2 || qn2 !== ~e2) begin
                miscompares++;
                $display("FAIL preset_prio[%0d]: q=%b qn=%b q2=%b qn2=%b, expected q=%b qn=%b q2=%b qn2=%b",
                         i, q, qn, q2, qn2, e, ~e, e2, ~e2);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] e, e2;
        for (int i = 0; i < 40; i++) begin
            to_low();
            apply($urandom_range(0, 7) == 0, $urandom_range(0, 5) != 0,
                  W'($urandom_range(0, 15)));
            next_edge();
            e = exp_q.pop_front();
            e2 = exp_cv_q.pop_front();
            vectors++;
            if (q !== e || qn !== ~e || q2 !== e2 || qn2 !== ~e2) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: q=%b qn=%b q2=%b qn2=%b, expected q=%b qn=%b q2=%b qn2=%b",
                         i, q, qn, q2, qn2, e, ~e, e2, ~e2);
            end
        end
    endtask

    initial begin
        clear  = 1'b0;
        preset = 1'b1;
        data   = '0;
        test_reset();
        test_capture();
        test_edge_sensitivity();
        test_hold_high();
        test_sync_clear();
        test_preset_priority();
        test_back_to_back();
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
